// File: rtl/correlator_sequencer.sv
// Sequencer that turns a stream of hit addresses into CLEAR/ACCUM/FINISH commands
// for the correlator block, waits for its best-sum result and holds it for a consumer.
module correlator_sequencer #(
  parameter int TIMEOUT  = 64,
  parameter int MAX_HITS = 48
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        hit_valid,
  output logic        hit_ready,
  input  logic [5:0]  hit_addr,
  input  logic        hit_last,
  output logic [1:0]  cmd_o,
  output logic [5:0]  addr_o,
  input  logic [26:0] max_sum_i,
  input  logic [7:0]  max_sumid_i,
  input  logic        max_sum_valid_i,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [26:0] res_sum,
  output logic [7:0]  res_id,
  output logic [5:0]  res_nhits,
  output logic [1:0]  res_flags,
  output logic        busy,
  output logic [15:0] evt_count
);

  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [5:0]  MAX_CNT = 6'(MAX_HITS);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_FINISH, S_WAIT, S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_CLEAR  = 2'b01,
    CMD_ACCUM  = 2'b10,
    CMD_FINISH = 2'b11
  } cmd_t;

  state_t        state, state_next;
  cmd_t          cmd_d;
  logic          rst_meta, rst_n;
  logic          transfer, issue;
  logic [5:0]    hit_cnt;
  logic [TW-1:0] tcnt;

  // NOTE: reset asserts asynchronously but releases through two flops, so every
  // downstream flop leaves reset on the same clean edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) {rst_n, rst_meta} <= 2'b00;
    else         {rst_n, rst_meta} <= {rst_meta, 1'b1};
  end

  // NOTE: sequential state only ever uses <=, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  assign transfer = hit_valid && hit_ready;
  assign issue    = transfer && (hit_cnt < MAX_CNT);

  // NOTE: each combinational block assigns a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (hit_valid) state_next = S_CLEAR;
      S_CLEAR:  state_next = S_ACCUM;
      S_ACCUM:  if (transfer && hit_last) state_next = S_FINISH;
      S_FINISH: state_next = S_WAIT;
      S_WAIT:   if (max_sum_valid_i || tcnt == '0) state_next = S_HOLD;
      S_HOLD:   if (res_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Commands are registered, so each one appears on cmd_o the cycle after the
  // state that produced it; this keeps the last ACCUM ahead of FINISH.
  always_comb begin
    hit_ready = 1'b0;
    res_valid = 1'b0;
    busy      = (state != S_IDLE);
    cmd_d     = CMD_NOP;
    case (state)
      S_CLEAR:  cmd_d = CMD_CLEAR;
      S_ACCUM: begin
        hit_ready = 1'b1;
        if (issue) cmd_d = CMD_ACCUM;
      end
      S_FINISH: cmd_d = CMD_FINISH;
      S_HOLD:   res_valid = 1'b1;
      default:  cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_o     <= CMD_NOP;
      addr_o    <= '0;
      hit_cnt   <= '0;
      res_flags <= '0;
      tcnt      <= '0;
      res_sum   <= '0;
      res_id    <= '0;
      evt_count <= '0;
    end else begin
      cmd_o <= cmd_d;
      if (issue) addr_o <= hit_addr;
      case (state)
        S_CLEAR: begin
          hit_cnt   <= '0;
          res_flags <= '0;
        end
        S_ACCUM: begin
          if (issue)         hit_cnt      <= hit_cnt + 6'd1;
          else if (transfer) res_flags[1] <= 1'b1;
        end
        S_FINISH: tcnt <= TW'(TIMEOUT);
        S_WAIT: begin
          if (tcnt != '0) tcnt <= tcnt - 1'b1;
          // A strobe arriving on the expiry cycle still wins over the timeout.
          if (max_sum_valid_i) begin
            res_sum <= max_sum_i;
            res_id  <= max_sumid_i;
          end else if (tcnt == '0) begin
            res_sum      <= '0;
            res_id       <= 8'hFF;
            res_flags[0] <= 1'b1;
          end
        end
        S_HOLD: if (res_ready) evt_count <= evt_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign res_nhits = hit_cnt;

endmodule

// File: doc/correlator_sequencer.md
CORRELATOR_SEQUENCER -- requirements
Module: correlator_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64: number of cycles to wait for the correlator result (minimum 2).
REQ-002 Parameter MAX_HITS, default 48: hits accepted per event (range 1..63).
REQ-003 Port clk, input, 1: single clock; every register is clocked on its rising edge.
REQ-004 Port arst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port hit_valid, input, 1: a hit address is offered.
REQ-006 Port hit_ready, output, 1: the sequencer accepts the offered hit.
REQ-007 Port hit_addr, input, 6: hit channel address.
REQ-008 Port hit_last, input, 1: the offered hit is the last hit of the event.
REQ-009 Port cmd_o, output, 2: command to the correlator block (00 NOP, 01 CLEAR, 10 ACCUM, 11 FINISH).
REQ-010 Port addr_o, output, 6: address to the correlator block; it is valid when cmd_o=ACCUM.
REQ-011 Port max_sum_i, input, 27: best sum from the correlator block.
REQ-012 Port max_sumid_i, input, 8: ID of the best sum.
REQ-013 Port max_sum_valid_i, input, 1: single-cycle strobe marking a valid best sum.
REQ-014 Port res_valid, output, 1: a result is held on the result outputs.
REQ-015 Port res_ready, input, 1: the consumer accepts the result.
REQ-016 Port res_sum, output, 27: latched best sum.
REQ-017 Port res_id, output, 8: latched best-sum ID.
REQ-018 Port res_nhits, output, 6: number of hits issued for the event.
REQ-019 Port res_flags, output, 2: bit0 = timeout, bit1 = hit overflow.
REQ-020 Port busy, output, 1: high whenever the state is not IDLE.
REQ-021 Port evt_count, output, 16: count of completed events; wraps from 0xFFFF to 0.

Function
REQ-022 The state machine SHALL have states IDLE, CLEAR, ACCUM, FINISH, WAIT and HOLD; cmd_o is registered.
REQ-023 IDLE: hit_ready=0, cmd_o=NOP; when hit_valid=1, the next state is CLEAR and the hit is not consumed.
REQ-024 CLEAR lasts exactly one cycle with cmd_o=CLEAR, zeroes the hit counter and the flags, then goes to ACCUM.
REQ-025 ACCUM: hit_ready=1; a transfer occurs when hit_valid&&hit_ready.
- On a transfer, the next cycle drives cmd_o=ACCUM with addr_o=hit_addr, and the hit counter increments.
- With no transfer, cmd_o=NOP.
REQ-026 A transfer with hit_last=1 SHALL move the state to FINISH after the ACCUM command is issued.
REQ-027 When the counter reaches MAX_HITS without hit_last, further hits SHALL be consumed (hit_ready=1) but not issued (cmd_o=NOP).
- flag bit1 is set.
- The state moves to FINISH on the first hit with hit_last=1.
REQ-028 FINISH lasts one cycle with cmd_o=FINISH, loads the timeout counter with TIMEOUT, then goes to WAIT.
REQ-029 WAIT: cmd_o=NOP, and the timeout counter decrements every cycle.
- On max_sum_valid_i=1: latch max_sum_i and max_sumid_i, then go to HOLD.
- On the counter reaching 0 with no strobe: res_sum=0, res_id=0xFF, flag bit0=1, then go to HOLD.
REQ-030 If the strobe and the expiry happen in the same cycle, the strobe SHALL win and bit0=0.
REQ-031 max_sum_valid_i asserted outside WAIT SHALL be ignored.
REQ-032 HOLD: res_valid=1, and res_sum, res_id, res_nhits and res_flags stay stable until res_ready=1.
- On res_ready=1: res_valid drops the next cycle, evt_count increments, and the state returns to IDLE.
REQ-033 res_valid SHALL be high only in HOLD, and the result outputs SHALL NOT change while res_valid=1.
REQ-034 Back-to-back events: a hit_valid present in the cycle after the HOLD→IDLE exit SHALL start a new CLEAR with no extra bubble beyond IDLE.
REQ-035 Latency:
- First accepted hit to its ACCUM command: 1 cycle.
- FINISH to result capture: at most TIMEOUT cycles.
- Capture to res_valid: 1 cycle.

Reset
REQ-036 While arst_n=0, all outputs SHALL be: state IDLE, cmd_o=NOP, addr_o=0, hit_ready=0, res_valid=0, res_sum=0, res_id=0, res_nhits=0, res_flags=0, busy=0, evt_count=0.
REQ-037 Assertion of arst_n mid-event SHALL abort the event immediately.
- No FINISH is issued.
- The next event starts with CLEAR.
REQ-038 Reset deassertion SHALL be synchronized to clk by a two-flop release synchronizer.
- The block leaves IDLE no earlier than the 2nd rising edge after deassertion.

Verification
REQ-039 Three hits (addresses 5, 17, 42; last on 42), strobe after 3 cycles of WAIT with sum=0x123, id=0x14.
- Required: cmd_o sequence CLEAR, ACCUM×3, FINISH.
- Result: res_sum=0x123, res_id=0x14, res_nhits=3, res_flags=0, evt_count=1.
REQ-040 One hit, no strobe, TIMEOUT=64.
- Required: res_valid rises 65 cycles after FINISH.
- Result: res_id=0xFF, res_flags=01, res_sum=0.
REQ-041 MAX_HITS=4 and six hits, last on the 6th.
- Required: exactly 4 ACCUM commands, res_nhits=4, res_flags=10, all 6 hits consumed.
REQ-042 res_ready held low for 20 cycles in HOLD while hit_valid=1 and the strobe pulses.
- Required: outputs stable, hit_ready=0, no new CLEAR.
- When res_ready=1: IDLE, then CLEAR.
REQ-043 arst_n pulsed low during ACCUM after 2 hits.
- Required: all outputs at reset values, with no FINISH emitted.
- A following event behaves exactly as in REQ-039.
REQ-044 Strobe and timeout expiry in the same WAIT cycle.
- Required: the strobe's sum and ID are latched and res_flags bit0=0.
